// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared types, widths and limit clamp for the counter sequencer
package count_sequencer_pkg;
   localparam int LIMIT_W = 4;
   localparam int STEPS_W = 8;
   localparam logic [LIMIT_W-1:0] LIMIT_MAX = LIMIT_W'(10);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} seq_state_t;
   function automatic logic [LIMIT_W-1:0] clamp_limit(input logic [LIMIT_W-1:0] l);
      return (l > LIMIT_MAX) ? LIMIT_MAX : l;
   endfunction
endpackage

// File: rtl/count_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on contention the requester not served last wins
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       win,
   output logic       valid
);
   always_comb begin
      valid = |req;
      win   = (&req) ? ~last : req[1];
   end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: arbitrates two requesters onto one modulo counter, runs it for a set step count
module count_sequencer
   import count_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req,
   input  logic [LIMIT_W-1:0] req_limit0,
   input  logic [LIMIT_W-1:0] req_limit1,
   input  logic [STEPS_W-1:0] req_steps0,
   input  logic [STEPS_W-1:0] req_steps1,
   input  logic               abort,
   output logic [1:0]         gnt,
   output logic [1:0]         done,
   output logic               aborted,
   output logic               busy,
   output logic               owner,
   output logic               cnt_clr,
   output logic               cnt_en,
   output logic [LIMIT_W-1:0] cnt_limit
);
   seq_state_t         state;
   logic [STEPS_W-1:0] rem;
   logic               last;
   logic               arb_win;
   logic               arb_valid;

   rr_arb2 u_arb (
      .req   (req),
      .last  (last),
      .win   (arb_win),
      .valid (arb_valid)
   );

   // reset pointer says requester 1 was served last, so requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rem       <= '0;
         last      <= 1'b1;
         gnt       <= '0;
         done      <= '0;
         aborted   <= 1'b0;
         busy      <= 1'b0;
         owner     <= 1'b0;
         cnt_clr   <= 1'b0;
         cnt_en    <= 1'b0;
         cnt_limit <= '0;
      end else begin
         gnt     <= '0;
         done    <= '0;
         cnt_clr <= 1'b0;
         case (state)
            IDLE: if (arb_valid) begin
               state     <= CLEAR;
               owner     <= arb_win;
               gnt       <= {arb_win, ~arb_win};
               cnt_clr   <= 1'b1;
               busy      <= 1'b1;
               cnt_limit <= clamp_limit(arb_win ? req_limit1 : req_limit0);
               rem       <= arb_win ? req_steps1 : req_steps0;
            end
            CLEAR: if (abort || rem == '0) begin
               state   <= DONE;
               done    <= {owner, ~owner};
               aborted <= abort;
            end else begin
               state  <= RUN;
               cnt_en <= 1'b1;
            end
            RUN: if (abort || rem == STEPS_W'(1)) begin
               state   <= DONE;
               cnt_en  <= 1'b0;
               done    <= {owner, ~owner};
               aborted <= abort;
            end else begin
               rem <= rem - STEPS_W'(1);
            end
            DONE: begin
               state   <= IDLE;
               busy    <= 1'b0;
               aborted <= 1'b0;
               last    <= owner;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: table-driven runs plus reset-mid-run and round-robin alternation sequences
module tb_count_sequencer;
   import count_sequencer_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [1:0]         req = '0;
   logic [LIMIT_W-1:0] req_limit0 = '0;
   logic [LIMIT_W-1:0] req_limit1 = '0;
   logic [STEPS_W-1:0] req_steps0 = '0;
   logic [STEPS_W-1:0] req_steps1 = '0;
   logic               abort = 1'b0;
   logic [1:0]         gnt;
   logic [1:0]         done;
   logic               aborted;
   logic               busy;
   logic               owner;
   logic               cnt_clr;
   logic               cnt_en;
   logic [LIMIT_W-1:0] cnt_limit;

   count_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_limit0 (req_limit0),
      .req_limit1 (req_limit1),
      .req_steps0 (req_steps0),
      .req_steps1 (req_steps1),
      .abort      (abort),
      .gnt        (gnt),
      .done       (done),
      .aborted    (aborted),
      .busy       (busy),
      .owner      (owner),
      .cnt_clr    (cnt_clr),
      .cnt_en     (cnt_en),
      .cnt_limit  (cnt_limit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]         rq;
      logic [LIMIT_W-1:0] l0, l1;
      logic [STEPS_W-1:0] s0, s1;
      int                 abort_at;
      logic               own;
      logic [LIMIT_W-1:0] lim;
      int                 n;
      logic               ab;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({gnt, done, aborted, busy, owner, cnt_clr, cnt_en, cnt_limit});
   endfunction

   task automatic run_vec(input int i, input vec_t v);
      int en, cyc, bad;
      req = v.rq;
      req_limit0 = v.l0;
      req_limit1 = v.l1;
      req_steps0 = v.s0;
      req_steps1 = v.s1;
      tick();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'({v.own, ~v.own}));
      chk($sformatf("v%0d_clr", i), 32'(cnt_clr), 32'd1);
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(v.own));
      chk($sformatf("v%0d_limit", i), 32'(cnt_limit), 32'(v.lim));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      req = '0;
      en = 0;
      cyc = 0;
      bad = 0;
      while (done == 2'b00 && cyc < 300) begin
         tick();
         cyc++;
         if (cnt_en) en++;
         if ((cnt_en && cnt_clr) || (gnt != 2'b00 && done != 2'b00)) bad++;
         abort = (v.abort_at != 0 && en == v.abort_at && done == 2'b00);
      end
      abort = 1'b0;
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(v.n + 1));
      chk($sformatf("v%0d_en_cycles", i), 32'(en), 32'(v.n));
      chk($sformatf("v%0d_done", i), 32'(done), 32'({v.own, ~v.own}));
      chk($sformatf("v%0d_aborted", i), 32'(aborted), 32'(v.ab));
      chk($sformatf("v%0d_overlap", i), 32'(bad), 32'd0);
      tick();
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_idle_done", i), 32'({done, aborted, cnt_en}), 32'd0);
      chk($sformatf("v%0d_limit_hold", i), 32'(cnt_limit), 32'(v.lim));
   endtask

   initial begin
      int ng;
      int gc[3];
      logic [1:0] gv[3];
      //            rq     l0     l1     s0      s1    abt own  lim    n  ab
      vecs[0] = '{2'b01, 4'd10, 4'd0,  8'd5,   8'd0, 0, 1'b0, 4'd10, 5, 1'b0};
      vecs[1] = '{2'b10, 4'd0,  4'd15, 8'd0,   8'd3, 0, 1'b1, 4'd10, 3, 1'b0};
      vecs[2] = '{2'b10, 4'd0,  4'd0,  8'd0,   8'd1, 0, 1'b1, 4'd0,  1, 1'b0};
      vecs[3] = '{2'b01, 4'd7,  4'd0,  8'd0,   8'd0, 0, 1'b0, 4'd7,  0, 1'b0};
      vecs[4] = '{2'b11, 4'd3,  4'd9,  8'd4,   8'd6, 0, 1'b1, 4'd9,  6, 1'b0};
      vecs[5] = '{2'b11, 4'd3,  4'd9,  8'd4,   8'd6, 0, 1'b0, 4'd3,  4, 1'b0};
      vecs[6] = '{2'b01, 4'd11, 4'd0,  8'd200, 8'd0, 3, 1'b0, 4'd10, 3, 1'b1};
      #1;
      chk("reset_outputs", all_outs(), 32'd0);
      #12 rst = 1'b1;
      tick();
      chk("post_reset_outputs", all_outs(), 32'd0);
      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      // reset asserted mid-run must clear outputs without waiting for an edge
      req = 2'b01;
      req_steps0 = 8'd200;
      tick();
      req = '0;
      tick();
      tick();
      chk("run_before_reset", 32'({busy, cnt_en}), 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("reset_async_outputs", all_outs(), 32'd0);
      tick();
      chk("reset_held_outputs", all_outs(), 32'd0);
      rst = 1'b1;
      req = 2'b11;
      req_limit0 = 4'd4;
      req_limit1 = 4'd5;
      req_steps0 = 8'd2;
      req_steps1 = 8'd2;
      ng = 0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (gnt != 2'b00 && ng < 3) begin
            gc[ng] = c;
            gv[ng] = gnt;
            ng++;
         end
      end
      req = '0;
      chk("alt_count", 32'(ng), 32'd3);
      if (ng == 3) begin
         chk("alt_cycle0", 32'(gc[0]), 32'd1);
         chk("alt_cycle1", 32'(gc[1]), 32'd6);
         chk("alt_cycle2", 32'(gc[2]), 32'd11);
         chk("alt_gnt0", 32'(gv[0]), 32'd1);
         chk("alt_gnt1", 32'(gv[1]), 32'd2);
         chk("alt_gnt2", 32'(gv[2]), 32'd1);
      end
      for (int c = 0; c < 8; c++) tick();
      chk("final_idle", 32'({busy, cnt_en, gnt, done}), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
